// File: rtl/fifo_pkg.sv
// Shared types and elaboration-time helpers for the parametrised synchronous FIFO.
// Imported by fifo_mem and sync_fifo_param.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Pointer width for a power-of-two depth; Count is one bit wider to hold Depth itself.
    function automatic int clog2_depth(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit depth_legal(input int depth);
        return is_pow2(depth) && (depth >= 4);
    endfunction

    function automatic bit thresholds_legal(input int depth, input int af_thr, input int ae_thr);
        return (af_thr >= 1) && (af_thr <= depth) && (ae_thr >= 0) && (ae_thr <= depth - 1);
    endfunction

    function automatic fifo_flags_t flags_for(input int count, input int depth,
                                              input int af_thr, input int ae_thr);
        fifo_flags_t f;
        f.full         = (count == depth);
        f.empty        = (count == 0);
        f.almost_full  = (count >= af_thr);
        f.almost_empty = (count <= ae_thr);
        return f;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port storage array for sync_fifo_param: synchronous write port and
// combinational (asynchronous) read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DataSize = 8,
    parameter int Depth    = 16,
    localparam int AddrW   = clog2_depth(Depth)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AddrW-1:0]    wr_addr,
    input  logic [DataSize-1:0] wr_data,
    input  logic [AddrW-1:0]    rd_addr,
    output logic [DataSize-1:0] rd_data
);

    logic [DataSize-1:0] mem [Depth];

    // NOTE: storage deliberately has no reset; the pointers and Count define which
    // entries are valid, so resetting the array would only cost routing and enables.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with standard or first-word-fall-through read mode, programmable
// almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int         DataSize       = 8,
    parameter int         Depth          = 16,
    parameter int         AlmostFullThr  = 14,
    parameter int         AlmostEmptyThr = 2,
    parameter fifo_mode_e Mode           = FIFO_STD
) (
    input  logic                         Clk,
    input  logic                         Resetn,
    input  logic                         Push,
    input  logic [DataSize-1:0]          DataIn,
    input  logic                         Pop,
    output logic [DataSize-1:0]          DataOut,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [clog2_depth(Depth):0]  Count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         ClrErr
);

    localparam int PtrW = clog2_depth(Depth);
    localparam int CntW = PtrW + 1;
    localparam fifo_flags_t ResetFlags = flags_for(0, Depth, AlmostFullThr, AlmostEmptyThr);

    if (DataSize < 1) begin : g_bad_width
        $error("sync_fifo_param: DataSize must be at least 1");
    end
    if (!depth_legal(Depth)) begin : g_bad_depth
        $error("sync_fifo_param: Depth must be a power of two and at least 4");
    end
    if (!thresholds_legal(Depth, AlmostFullThr, AlmostEmptyThr)) begin : g_bad_thr
        $error("sync_fifo_param: almost-full/almost-empty thresholds out of range");
    end

    logic [PtrW-1:0]     wr_ptr;
    logic [PtrW-1:0]     rd_ptr;
    logic [CntW-1:0]     count_q;
    logic [CntW-1:0]     count_next;
    fifo_flags_t         flags_q;
    fifo_flags_t         flags_next;
    logic                wr_en;
    logic                rd_en;
    logic [DataSize-1:0] rd_data;

    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign wr_en      = Push && (!flags_q.full || Pop);
    assign rd_en      = Pop && !flags_q.empty;
    assign count_next = count_q + CntW'(wr_en) - CntW'(rd_en);
    assign flags_next = flags_for(int'(count_next), Depth, AlmostFullThr, AlmostEmptyThr);

    fifo_mem #(
        .DataSize (DataSize),
        .Depth    (Depth)
    ) u_mem (
        .clk     (Clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (DataIn),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            flags_q <= ResetFlags;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            count_q <= count_next;
            flags_q <= flags_next;
        end
    end

    // A new error in the same cycle as ClrErr leaves the flag set.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (Push && !wr_en) begin
                overflow <= 1'b1;
            end else if (ClrErr) begin
                overflow <= 1'b0;
            end
            if (Pop && !rd_en) begin
                underflow <= 1'b1;
            end else if (ClrErr) begin
                underflow <= 1'b0;
            end
        end
    end

    if (Mode == FIFO_STD) begin : g_std
        logic [DataSize-1:0] dout_q;

        always_ff @(posedge Clk or negedge Resetn) begin
            if (!Resetn) begin
                dout_q <= '0;
            end else if (rd_en) begin
                dout_q <= rd_data;
            end
        end

        assign DataOut = dout_q;
    end else begin : g_fwft
        // Head word is shown directly; forced to zero while empty so reset reads as 0.
        assign DataOut = flags_q.empty ? '0 : rd_data;
    end

    assign Count        = count_q;
    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: one FIFO_STD and one FIFO_FWFT instance
// driven with identical stimulus and compared against a queue-based reference model.
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int W   = 8;
    localparam int D   = 16;
    localparam int AFT = 14;
    localparam int AET = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         push, pop, clr;
    logic [W-1:0] din;

    logic [W-1:0] s_dout, f_dout;
    logic [4:0]   s_count, f_count;
    logic         s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic         f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queue of words plus the sticky error bits.
    logic [W-1:0] q[$];
    logic [W-1:0] m_std_dout = '0;
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DataSize(W), .Depth(D), .AlmostFullThr(AFT), .AlmostEmptyThr(AET), .Mode(FIFO_STD)
    ) u_std (
        .Clk(clk), .Resetn(rst_n), .Push(push), .DataIn(din), .Pop(pop), .DataOut(s_dout),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .Count(s_count), .overflow(s_ovf), .underflow(s_unf), .ClrErr(clr)
    );

    sync_fifo_param #(
        .DataSize(W), .Depth(D), .AlmostFullThr(AFT), .AlmostEmptyThr(AET), .Mode(FIFO_FWFT)
    ) u_fwft (
        .Clk(clk), .Resetn(rst_n), .Push(push), .DataIn(din), .Pop(pop), .DataOut(f_dout),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .Count(f_count), .overflow(f_ovf), .underflow(f_unf), .ClrErr(clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit p, input bit o, input bit c, input logic [W-1:0] d);
        bit acc_pop;
        bit acc_push;
        acc_pop  = o && (q.size() > 0);
        acc_push = p && ((q.size() < D) || o);
        if (acc_pop) m_std_dout = q.pop_front();
        if (acc_push) q.push_back(d);
        if (p && !acc_push) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (o && !acc_pop) m_unf = 1'b1;
        else if (c) m_unf = 1'b0;
    endtask

    task automatic cycle(input bit p, input bit o, input bit c, input logic [W-1:0] d);
        push = p;
        pop  = o;
        clr  = c;
        din  = d;
        @(posedge clk);
        #1;
        model_step(p, o, c, d);
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        check({tag, " std count"}, 32'(s_count), 32'(n));
        check({tag, " fwft count"}, 32'(f_count), 32'(n));
        check({tag, " std full"}, 32'(s_full), 32'(n == D));
        check({tag, " std empty"}, 32'(s_empty), 32'(n == 0));
        check({tag, " std almost_full"}, 32'(s_af), 32'(n >= AFT));
        check({tag, " std almost_empty"}, 32'(s_ae), 32'(n <= AET));
        check({tag, " fwft flags"}, {28'd0, f_full, f_empty, f_af, f_ae},
              {28'd0, n == D, n == 0, n >= AFT, n <= AET});
        check({tag, " std overflow"}, 32'(s_ovf), 32'(m_ovf));
        check({tag, " std underflow"}, 32'(s_unf), 32'(m_unf));
        check({tag, " fwft errors"}, {30'd0, f_ovf, f_unf}, {30'd0, m_ovf, m_unf});
        check({tag, " std dout"}, 32'(s_dout), 32'(m_std_dout));
        if (n > 0) check({tag, " fwft dout"}, 32'(f_dout), 32'(q[0]));
    endtask

    typedef struct {
        bit           push;
        bit           pop;
        logic [W-1:0] din;
        int           count;
        bit           full;
        bit           empty;
        bit           af;
        bit           ae;
        bit           ovf;
        logic [W-1:0] dout;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 1'b0, W'(i), i + 1, (i + 1) == D, 1'b0,
                        (i + 1) >= AFT, (i + 1) <= AET, 1'b0, 8'h00};
        end
        vecs[16] = '{1'b1, 1'b0, 8'hAA, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};

        rst_n = 1'b0;
        push = 1'b0; pop = 1'b0; clr = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;

        // Fill with 0x00..0x0F, then a rejected push of 0xAA.
        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].push, vecs[i].pop, 1'b0, vecs[i].din);
            check($sformatf("fill[%0d] count", i), 32'(s_count), 32'(vecs[i].count));
            check($sformatf("fill[%0d] flags", i), {28'd0, s_full, s_empty, s_af, s_ae},
                  {28'd0, vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae});
            check($sformatf("fill[%0d] overflow", i), 32'(s_ovf), 32'(vecs[i].ovf));
            check($sformatf("fill[%0d] dout", i), 32'(s_dout), 32'(vecs[i].dout));
            check($sformatf("fill[%0d] fwft count", i), 32'(f_count), 32'(vecs[i].count));
        end
        check_model("after overflow");

        // Drain in order; 0xAA must never appear.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            check($sformatf("drain[%0d] std dout", i), 32'(s_dout), 32'(i));
            if (i < 15) check($sformatf("drain[%0d] fwft dout", i), 32'(f_dout), 32'(i + 1));
        end
        check("drained empty", 32'(s_empty), 32'd1);
        check_model("drained");

        // Full with simultaneous push+pop.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, W'(i));
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h55);
            check($sformatf("full pp[%0d] count", k), 32'(s_count), 32'd16);
            check($sformatf("full pp[%0d] dout", k), 32'(s_dout), 32'(k));
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            check($sformatf("full pp drain[%0d]", i), 32'(s_dout), (i < 12) ? 32'(i + 4) : 32'h55);
        end
        check_model("full pp drained");

        // Empty with simultaneous push+pop: only the push is taken.
        cycle(1'b1, 1'b1, 1'b0, 8'h33);
        check("empty pp underflow", 32'(s_unf), 32'd1);
        check("empty pp count", 32'(s_count), 32'd1);
        check("empty pp dout held", 32'(s_dout), 32'h55);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("clr overflow", 32'(s_ovf), 32'd0);
        check("clr underflow", 32'(s_unf), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("pop 0x33", 32'(s_dout), 32'h33);
        // Error and clear in the same cycle: error wins.
        cycle(1'b0, 1'b1, 1'b1, '0);
        check("clr vs underflow", 32'(s_unf), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check_model("after clr");

        // FWFT visibility.
        cycle(1'b1, 1'b0, 1'b0, 8'h11);
        check("fwft first word", 32'(f_dout), 32'h11);
        check("fwft not empty", 32'(f_empty), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'h22);
        check("fwft head holds", 32'(f_dout), 32'h11);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("fwft next word", 32'(f_dout), 32'h22);
        check("std after pop", 32'(s_dout), 32'h11);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check_model("fwft drained");

        // Random traffic, alternating push-heavy and pop-heavy phases so pointers wrap.
        for (int n = 0; n < 300; n++) begin
            bit heavy_push;
            bit p, o, c;
            heavy_push = ((n / 50) % 2) == 0;
            p = $urandom_range(0, 99) < (heavy_push ? 75 : 35);
            o = $urandom_range(0, 99) < (heavy_push ? 35 : 75);
            c = $urandom_range(0, 19) == 0;
            cycle(p, o, c, W'($urandom));
            check_model($sformatf("rand[%0d]", n));
        end

        // Asynchronous reset between clock edges with data present.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, W'(8'hC0 + i));
        cycle(1'b0, 1'b0, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_std_dout = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check("async reset fwft dout", 32'(f_dout), 32'd0);
        check_model("async reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 8'h5A);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check_model("post reset");

        push = 1'b0; pop = 1'b0; clr = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
